// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with a one-word output register per channel.
// Optional per-channel delivered-word counters are compiled in with DEMUX_CNT_EN.
module demux1to2_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_sel,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Y0_data,
    output logic             Y0_valid,
    input  logic             Y0_ready,
    output logic [WIDTH-1:0] Y1_data,
    output logic             Y1_valid,
    input  logic             Y1_ready,
    input  logic             Clr_cnt,
    output logic [CNT_W-1:0] Count0,
    output logic [CNT_W-1:0] Count1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    logic [1:0]            out_ready;
    logic [1:0]            slot_free;
    logic [1:0]            chan_valid;
    logic [1:0][WIDTH-1:0] chan_data;
    logic [1:0][CNT_W-1:0] chan_cnt;
    logic                  accept;

    assign out_ready = {Y1_ready, Y0_ready};
    // A slot can take a word if empty, or if it is draining this very cycle.
    assign In_ready  = ~reset & slot_free[In_sel];
    assign accept    = In_valid & In_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            slot_state_e      state_q, state_d;
            logic [WIDTH-1:0] data_q, data_d;
            logic             load;
            logic             drain;

            assign load          = accept & (In_sel == 1'(gi));
            assign drain         = (state_q == FULL) & out_ready[gi];
            assign slot_free[gi] = (state_q == EMPTY) | out_ready[gi];

            always_comb begin
                state_d = state_q;
                data_d  = data_q;
                if (load) begin
                    state_d = FULL;
                    data_d  = In_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= EMPTY;
                    data_q  <= '0;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                end
            end

            assign chan_valid[gi] = (state_q == FULL);
            assign chan_data[gi]  = data_q;

`ifdef DEMUX_CNT_EN
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Clear wins over a same-cycle drain; the count wraps freely.
            always_comb begin
                cnt_d = cnt_q;
                if (Clr_cnt) begin
                    cnt_d = '0;
                end else if (drain) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign chan_cnt[gi] = cnt_q;
`else
            assign chan_cnt[gi] = '0;
`endif
        end
    endgenerate

`ifndef DEMUX_CNT_EN
    logic unused_clr;
    assign unused_clr = Clr_cnt;
`endif

    assign Y0_valid = chan_valid[0];
    assign Y1_valid = chan_valid[1];
    assign Y0_data  = chan_data[0];
    assign Y1_data  = chan_data[1];
    assign Count0   = chan_cnt[0];
    assign Count1   = chan_cnt[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream: a per-cycle vector table plus
// hand-written throughput/wrap and asynchronous-reset sequences.
module tb_demux1to2_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
`ifdef DEMUX_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_valid, in_ready;
    logic [WIDTH-1:0] y0_data, y1_data;
    logic             y0_valid, y1_valid, y0_ready, y1_ready;
    logic             clr_cnt;
    logic [CNT_W-1:0] count0, count1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .In_data(in_data), .In_sel(in_sel), .In_valid(in_valid), .In_ready(in_ready),
        .Y0_data(y0_data), .Y0_valid(y0_valid), .Y0_ready(y0_ready),
        .Y1_data(y1_data), .Y1_valid(y1_valid), .Y1_ready(y1_ready),
        .Clr_cnt(clr_cnt), .Count0(count0), .Count1(count1)
    );

    typedef struct {
        logic [3:0] d;
        logic       s, v, r0, r1, clr;
        logic       rdy, y0v;
        logic [3:0] y0d;
        logic       y1v;
        logic [3:0] y1d;
        logic [7:0] c0, c1;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [3:0] d, input logic s, v, r0, r1, clr,
                        input logic rdy, y0v, input logic [3:0] y0d,
                        input logic y1v, input logic [3:0] y1d,
                        input logic [7:0] c0, c1);
        vec_t t;
        t.d = d; t.s = s; t.v = v; t.r0 = r0; t.r1 = r1; t.clr = clr;
        t.rdy = rdy; t.y0v = y0v; t.y0d = y0d; t.y1v = y1v; t.y1d = y1d;
        t.c0 = c0; t.c1 = c1;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cexp(input int c);
        return CNT_ON ? c : 0;
    endfunction

    task automatic drive(input logic [3:0] d, input logic s, v, r0, r1, clr);
        in_data = d; in_sel = s; in_valid = v;
        y0_ready = r0; y1_ready = r1; clr_cnt = clr;
    endtask

    initial begin
        reset = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   d    s  v  r0 r1 clr | rdy y0v y0d  y1v y1d  c0 c1
        addv(4'h0, 0, 0, 1, 1, 0,   1,  0, 4'h0, 0, 4'h0, 0, 0);
        addv(4'h5, 1, 1, 0, 1, 0,   1,  0, 4'h0, 0, 4'h0, 0, 0);
        addv(4'h0, 0, 0, 0, 1, 0,   1,  0, 4'h0, 1, 4'h5, 0, 0);
        addv(4'h0, 0, 0, 0, 0, 0,   1,  0, 4'h0, 0, 4'h5, 0, 1);
        addv(4'h3, 0, 1, 0, 0, 0,   1,  0, 4'h0, 0, 4'h5, 0, 1);
        addv(4'h7, 0, 1, 0, 0, 0,   0,  1, 4'h3, 0, 4'h5, 0, 1);
        addv(4'h7, 0, 1, 0, 0, 0,   0,  1, 4'h3, 0, 4'h5, 0, 1);
        addv(4'h9, 1, 1, 0, 0, 0,   1,  1, 4'h3, 0, 4'h5, 0, 1);
        addv(4'h7, 0, 1, 1, 0, 0,   1,  1, 4'h3, 1, 4'h9, 0, 1);
        addv(4'h0, 0, 0, 1, 0, 0,   1,  1, 4'h7, 1, 4'h9, 1, 1);
        addv(4'h0, 1, 0, 0, 1, 1,   1,  0, 4'h7, 1, 4'h9, 2, 1);
        addv(4'h0, 0, 0, 0, 0, 0,   1,  0, 4'h7, 0, 4'h9, 0, 0);
        addv(4'h4, 0, 1, 0, 0, 0,   1,  0, 4'h7, 0, 4'h9, 0, 0);
        addv(4'h6, 0, 1, 0, 0, 0,   0,  1, 4'h4, 0, 4'h9, 0, 0);
        addv(4'h6, 1, 1, 0, 0, 0,   1,  1, 4'h4, 0, 4'h9, 0, 0);
        addv(4'h0, 0, 0, 0, 0, 0,   0,  1, 4'h4, 1, 4'h6, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].r0, vecs[i].r1, vecs[i].clr);
            #1;
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].rdy));
            chk($sformatf("v%0d_y0_valid", i), int'(y0_valid), int'(vecs[i].y0v));
            chk($sformatf("v%0d_y0_data", i),  int'(y0_data),  int'(vecs[i].y0d));
            chk($sformatf("v%0d_y1_valid", i), int'(y1_valid), int'(vecs[i].y1v));
            chk($sformatf("v%0d_y1_data", i),  int'(y1_data),  int'(vecs[i].y1d));
            chk($sformatf("v%0d_count0", i),   int'(count0),   cexp(int'(vecs[i].c0)));
            chk($sformatf("v%0d_count1", i),   int'(count1),   cexp(int'(vecs[i].c1)));
            $display("vec %0d: d=%0h sel=%0b v=%0b rdy=%0b y0=%0b/%0h y1=%0b/%0h c=%0d/%0d",
                     i, vecs[i].d, vecs[i].s, vecs[i].v, in_ready,
                     y0_valid, y0_data, y1_valid, y1_data, count0, count1);
            @(negedge clk);
        end

        // Drain both channels while clearing, so the throughput run starts from zero.
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("pre_tp_count0", int'(count0), 0);
        chk("pre_tp_y0_valid", int'(y0_valid), 0);
        @(negedge clk);

        // 260 back-to-back words to channel 0: one per cycle, counter wraps to 4.
        for (int i = 0; i < 260; i++) begin
            drive(4'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("tp%0d_in_ready", i), int'(in_ready), 1);
            if (i > 0) begin
                chk($sformatf("tp%0d_y0_valid", i), int'(y0_valid), 1);
                chk($sformatf("tp%0d_y0_data", i), int'(y0_data), (i - 1) % 16);
            end
            @(negedge clk);
        end
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("tp_last_data", int'(y0_data), 259 % 16);
        @(negedge clk);
        #1;
        chk("tp_count0_wrap", int'(count0), cexp(4));
        chk("tp_y0_empty", int'(y0_valid), 0);
        $display("throughput: 260 words, count0=%0d", count0);

        // Load 4'hA into a stalled Y0, then reset asynchronously mid-cycle.
        drive(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_y0_valid", int'(y0_valid), 1);
        chk("pre_rst_y0_data", int'(y0_data), 4'hA);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_y0_valid", int'(y0_valid), 0);
        chk("arst_y0_data", int'(y0_data), 0);
        chk("arst_count0", int'(count0), 0);
        chk("arst_y1_data", int'(y1_data), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        $display("async reset: y0=%0b/%0h count0=%0d in_ready=%0b",
                 y0_valid, y0_data, count0, in_ready);
        @(negedge clk);
        reset = 1'b0;

        // First accept after reset behaves normally.
        drive(4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("post_rst_y1_valid", int'(y1_valid), 1);
        chk("post_rst_y1_data", int'(y1_data), 4'hB);
        chk("post_rst_y0_valid", int'(y0_valid), 0);
        @(negedge clk);
        #1;
        chk("post_rst_count1", int'(count1), cexp(1));
        $display("post-reset accept: y1=%0b/%0h count1=%0d", y1_valid, y1_data, count1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1to2_stream.md
Name: demux1to2_stream

Overview:
Registered 1-to-2 stream demultiplexer. It is the distribution counterpart of the 2-to-1 mux used in the ALU datapath.
- One input stream, with a valid/ready handshake and a per-word Selector, is steered to one of two output channels.
- Each output channel has a one-word output register, so output timing is decoupled from the input.
- Per-channel delivered-word counters are optional.
- Sits between the ALU result bus and the two downstream consumers (result register and display path).

Parameters:
WIDTH, 4, data word width in bits
CNT_W, 8, width of each delivered-word counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
In_data  input  WIDTH  input word
In_sel  input  1  target channel for In_data (0 -> Y0, 1 -> Y1)
In_valid  input  1  In_data/In_sel are valid this cycle
In_ready  output  1  block accepts the word this cycle
Y0_data  output  WIDTH  channel 0 word (registered)
Y0_valid  output  1  channel 0 holds a word
Y0_ready  input  1  channel 0 consumer accepts
Y1_data  output  WIDTH  channel 1 word (registered)
Y1_valid  output  1  channel 1 holds a word
Y1_ready  input  1  channel 1 consumer accepts
Clr_cnt  input  1  synchronous clear of both counters
Count0  output  CNT_W  words delivered on channel 0
Count1  output  CNT_W  words delivered on channel 1

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- While reset is high (asynchronous, immediate):
  - Y0_valid=0, Y1_valid=0.
  - Y0_data=0, Y1_data=0.
  - Count0=0, Count1=0.
  - Any word held in the output registers is discarded.
  - In_ready is forced to 0 while reset is asserted.
- Each channel n is a two-state machine:
  - EMPTY (Yn_valid=0) and FULL (Yn_valid=1). The state is Yn_valid itself.
- Slot n is free when Yn_valid=0, or when Yn_valid=1 and Yn_ready=1 (drain and refill in the same cycle).
- In_ready is combinational:
  - In_ready = slot[In_sel] free.
  - In_ready does not depend on the non-selected channel.
- Accept happens when In_valid and In_ready are both 1.
  - On the next edge, Yn_data <= In_data and Yn_valid <= 1, where n = In_sel.
  - Latency: 1 cycle, accept edge to Yn_valid.
- Drain happens when Yn_valid and Yn_ready are both 1.
  - If channel n is not accepting the same cycle, Yn_valid <= 0 on the next edge.
  - Yn_data holds its last value after a drain; it is never cleared except by reset.
- While Yn_valid=1 and Yn_ready=0, Yn_data is stable. No word is overwritten or lost.
- Channels are independent: one channel can drain while the other accepts in the same cycle.
- Back-to-back operation: with Yn_ready held at 1, channel n sustains one word per cycle.
- In_sel is sampled only on an accepted cycle. A change in In_sel while In_valid=1 with no accept is allowed.
- Counters (when compiled in):
  - Countn increments by 1 on each channel-n drain handshake.
  - Countn wraps modulo 2^CNT_W; there is no saturation.
  - Clr_cnt=1 zeroes both counters on the next edge and takes priority over a same-cycle increment.
- Reset mid-transfer: a held word is dropped and the counters restart at 0. After reset deasserts, the first accept behaves normally.

Optional Feature:
- Macro name: DEMUX_CNT_EN.
- Defined: Count0/Count1 and Clr_cnt behave as described above.
- Undefined:
  - No counter flops are synthesised.
  - Count0 and Count1 are tied to constant 0.
  - Clr_cnt is ignored.
  - The data and handshake behaviour is identical in both cases.

Test Plan:
1. Reset: assert reset mid-simulation with Y0 FULL holding 4'hA -> Y0_valid=0, Y0_data=0, Count0=0 immediately, with no clock edge needed.
2. Single route: In_data=4'h5, In_sel=1, In_valid=1 for one cycle, Y1_ready=1 -> next cycle Y1_valid=1 and Y1_data=5, Y0_valid stays 0 -> after drain, Count1=1 (DEMUX_CNT_EN defined).
3. Backpressure: Y0_ready=0, send 4'h3 then 4'h7 to channel 0 -> second word sees In_ready=0 and Y0_data stays 3 -> raise Y0_ready -> 3 drains, then 7 is accepted and appears the following cycle.
4. Independence: Y0 FULL and stalled, In_sel=1 -> In_ready=1 and the word lands in Y1 while Y0_data is unchanged.
5. Throughput and wrap: CNT_W=8, Y0_ready=1, send 260 consecutive words to channel 0 -> one word per cycle, Count0=4.
6. Counter clear: Clr_cnt=1 on the same cycle as a channel-1 drain -> Count1=0 next cycle. Without DEMUX_CNT_EN, Count0 and Count1 stay 0 throughout scenarios 2-6.
